ex_wb_stage: RTL

Execute/writeback stage that consumes the ID/EX pipeline-register bundle of the 8-bit core. It performs the ALU operation, issues single-cycle-latency data-memory loads, resolves branches and drives the register-file write port. It feeds writeback results back into its own operand path (forwarding) and tells upstream stages when to stall or flush. Sits between the ID/EX register and the register file / data memory.

---
 rtl/ex_pkg.sv | 16 +
 rtl/ex_alu.sv | 22 ++
 rtl/ex_wb_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the 8-bit core's execute/writeback stage.
package ex_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic {
    EXEC = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic ALU_ADD  = 1'b0;
  localparam logic ALU_PASS = 1'b1;
  localparam int   REG_ZERO = 0;

endpackage

// File: rtl/ex_alu.sv
// Execute-stage ALU: selects operand B, then produces the sum and the selected result.
import ex_pkg::*;

module ex_alu #(
  parameter int DATA_W = ex_pkg::DATA_W
) (
  input  logic              alu_ctrl,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] op_b;

  assign op_b   = alu_src ? imm : '0;
  // Load addresses always use the sum, whatever alu_ctrl says.
  assign sum    = op_a + op_b;
  assign result = (alu_ctrl == ALU_PASS) ? op_b : sum;

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: ALU, single-cycle loads, branches, squash and forwarding.
// Optional build macro EX_FORWARD_EN enables operand-A forwarding from writeback.
//   state | meaning
//   EXEC  | accepting instructions from ID/EX
//   LOAD  | load in flight, upstream stalled, writeback at the next edge
import ex_pkg::*;

module ex_wb_stage #(
  parameter int DATA_W = ex_pkg::DATA_W,
  parameter int ADDR_W = ex_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              reg_write,
  input  logic              alu_ctrl,
  input  logic              alu_src,
  input  logic              mem_to_reg,
  input  logic              pc_src,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] imm,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] pc,
  output logic              stall,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              dmem_rd_en,
  output logic [DATA_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  state_t            state;
  logic              squash;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] alu_sum;
  logic [DATA_W-1:0] alu_result;
  logic              take;
  logic              accept;
  logic              wr_ok;

  assign stall  = (state == LOAD);
  assign take   = id_valid && !stall;
  assign accept = take && !squash;
  assign wr_ok  = reg_write && (wr_addr != ADDR_W'(REG_ZERO));

`ifdef EX_FORWARD_EN
  assign op_a = (wb_en && (wb_addr == src_addr) && (src_addr != ADDR_W'(REG_ZERO)))
                ? wb_data : data1;
`else
  logic unused_src;
  assign unused_src = ^src_addr;
  assign op_a       = data1;
`endif

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_ctrl (alu_ctrl),
    .alu_src  (alu_src),
    .op_a     (op_a),
    .imm      (imm),
    .sum      (alu_sum),
    .result   (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= EXEC;
      squash         <= 1'b0;
      load_we        <= 1'b0;
      load_addr      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      dmem_rd_en     <= 1'b0;
      dmem_addr      <= '0;
      wb_en          <= 1'b0;
      wb_addr        <= '0;
      wb_data        <= '0;
    end else begin
      wb_en          <= 1'b0;
      redirect_valid <= 1'b0;
      dmem_rd_en     <= 1'b0;
      case (state)
        EXEC: begin
          if (take && squash) begin
            squash <= 1'b0;
          end else if (accept) begin
            if (pc_src) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= pc + imm;
              wb_en          <= wr_ok;
              wb_addr        <= wr_addr;
              wb_data        <= pc + DATA_W'(1);
              squash         <= 1'b1;
            end else if (mem_to_reg) begin
              state      <= LOAD;
              dmem_rd_en <= 1'b1;
              dmem_addr  <= alu_sum;
              load_we    <= wr_ok;
              load_addr  <= wr_addr;
            end else begin
              wb_en   <= wr_ok;
              wb_addr <= wr_addr;
              wb_data <= alu_result;
            end
          end
        end
        LOAD: begin
          // Read data is valid only while the strobe is up, so capture it here.
          state   <= EXEC;
          wb_en   <= load_we;
          wb_addr <= load_addr;
          wb_data <= dmem_rdata;
        end
        default: state <= EXEC;
      endcase
    end
  end

endmodule
